// File: rtl/slot_snap_ctrl.sv
// Snapshot controller for 32-slot multiplexed pipeline signals: aligns to slot 0,
// captures one full frame into a buffer, then streams it out over valid/ready.
module slot_snap_ctrl #(
  parameter int W   = 10,
  parameter int STG = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cen,
  input  logic [W-1:0] mixed,
  input  logic [4:0]   cnt,
  input  logic         trig,
  input  logic         abort,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [4:0]   out_slot,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE,
    ALIGN,
    CAPTURE,
    DRAIN
  } state_t;

  // (cnt + 33 - STG) mod 32 folded into a single 5-bit offset; identical result
  localparam logic [4:0] SLOT_OFS = 5'((33 - STG) % 32);

  state_t       state;
  logic [4:0]   slot;
  logic [4:0]   widx;
  logic [4:0]   ridx;
  logic         wr_en;
  logic [W-1:0] mem [32];

  assign slot = cnt + SLOT_OFS;

  always_comb begin
    wr_en = 1'b0;
    if (cen && !abort) begin
      case (state)
        ALIGN:   wr_en = (slot == 5'd0);
        CAPTURE: wr_en = (slot == widx);
        default: wr_en = 1'b0;
      endcase
    end
  end

  // widx is held at 0 throughout ALIGN, so it addresses the slot-0 write too
  always_ff @(posedge clk) begin
    if (wr_en) mem[widx] <= mixed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_slot  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      widx      <= '0;
      ridx      <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        out_valid <= 1'b0;
        widx      <= '0;
        ridx      <= '0;
      end else begin
        case (state)
          IDLE: begin
            // done is high only in the first IDLE cycle; a trig there is dropped
            if (trig && !done) begin
              state <= ALIGN;
              busy  <= 1'b1;
              widx  <= '0;
              ridx  <= '0;
            end
          end
          ALIGN: begin
            if (cen && slot == 5'd0) begin
              widx  <= 5'd1;
              state <= CAPTURE;
            end
          end
          CAPTURE: begin
            if (cen) begin
              if (slot == widx) begin
                widx <= widx + 5'd1;
                if (widx == 5'd31) begin
                  state     <= DRAIN;
                  ridx      <= '0;
                  out_valid <= 1'b1;
                  out_data  <= mem[0];
                  out_slot  <= '0;
                end
              end else begin
                err   <= 1'b1;
                widx  <= '0;
                state <= ALIGN;
              end
            end
          end
          DRAIN: begin
            if (out_valid && out_ready) begin
              if (ridx == 5'd31) begin
                out_valid <= 1'b0;
                done      <= 1'b1;
                busy      <= 1'b0;
                ridx      <= '0;
                state     <= IDLE;
              end else begin
                ridx     <= ridx + 5'd1;
                out_data <= mem[ridx + 5'd1];
                out_slot <= ridx + 5'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_slot_snap_ctrl.sv
// Directed bench for slot_snap_ctrl: STG=0 instance for most scenarios,
// STG=8 instance with a sparse clock enable for the alignment scenario.
module tb_slot_snap_ctrl;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, cen, trig, abort, out_ready;
  logic [4:0] cnt;
  logic [9:0] mixed;
  logic       busy, out_valid, done, err;
  logic [9:0] out_data;
  logic [4:0] out_slot;

  logic       cen8, trig8, abort8, out_ready8;
  logic [4:0] cnt8, s8;
  logic [9:0] mixed8;
  logic       busy8, out_valid8, done8, err8;
  logic [9:0] out_data8;
  logic [4:0] out_slot8;

  int total = 0;
  int bad   = 0;
  bit skip_armed = 1'b0;
  int phase = 0;

  slot_snap_ctrl #(.W(10), .STG(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .mixed(mixed), .cnt(cnt),
    .trig(trig), .abort(abort), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_slot(out_slot),
    .done(done), .err(err)
  );

  slot_snap_ctrl #(.W(10), .STG(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cen(cen8), .mixed(mixed8), .cnt(cnt8),
    .trig(trig8), .abort(abort8), .busy(busy8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .out_slot(out_slot8),
    .done(done8), .err(err8)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // STG=0: slot = cnt+1 and mixed = cnt+100, so slot k carries ((k-1) mod 32)+100
  function automatic logic [9:0] exp0(input int k);
    return 10'(((k + 31) % 32) + 100);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (cen) begin
      if (skip_armed && cnt == 5'd10) begin
        cnt = 5'd12;
        skip_armed = 1'b0;
      end else begin
        cnt = cnt + 5'd1;
      end
    end
    mixed = {5'b0, cnt} + 10'd100;
    if (cen8) cnt8 = cnt8 + 5'd1;
    phase  = (phase + 1) % 4;
    cen8   = (phase == 0);
    s8     = cnt8 + 5'd25;
    mixed8 = {5'b0, s8} * 10'd3;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!out_valid && n < bound) begin
      step();
      n++;
    end
    if (!out_valid) check("wait_valid_timeout", 0, 1);
  endtask

  task automatic trig_at(input logic [4:0] c);
    int n;
    n = 0;
    while (cnt != c && n < 64) begin
      step();
      n++;
    end
    trig = 1'b1;
    step();
    trig = 1'b0;
  endtask

  // kind: 0 = run to completion, 1 = abort at entry stop_k, 2 = async reset at entry stop_k
  task automatic drain(input int pct, input int stop_k, input int kind, input bit hold_trig,
                       output int nhs, output int ndone);
    logic [9:0] hd, d;
    logic [4:0] hs, s;
    bit held, v, rdy;
    int c;
    nhs = 0; ndone = 0; held = 1'b0; c = 0;
    hd = '0; hs = '0;
    while (busy && c < 800) begin
      if (held) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hd);
        check("hold_slot", out_slot, hs);
      end
      if (kind != 0 && nhs == stop_k) begin
        if (kind == 1) begin
          abort = 1'b1; out_ready = 1'b1; trig = 1'b0;
          step();
          abort = 1'b0;
          check("abort_busy", busy, 0);
          check("abort_valid", out_valid, 0);
          check("abort_done", done, 0);
        end else begin
          #2 rst_n = 1'b0;
          #1;
          check("rst_valid", out_valid, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_slot", out_slot, 0);
          check("rst_data", out_data, 0);
          trig = 1'b0;
        end
        out_ready = 1'b0;
        return;
      end
      rdy = (pct >= 100) || ($urandom_range(0, 99) < pct);
      out_ready = rdy;
      trig = hold_trig;
      v = out_valid; d = out_data; s = out_slot;
      step();
      c++;
      if (done) ndone++;
      if (v && rdy) begin
        check("entry_slot", s, nhs);
        check("entry_data", d, exp0(nhs));
        nhs++;
        held = 1'b0;
        if (nhs == 32) begin
          check("last_done", done, 1);
          check("last_valid", out_valid, 0);
          check("last_busy", busy, 0);
        end
      end else begin
        held = v; hd = d; hs = s;
      end
    end
    if (busy) check("drain_timeout", 0, 1);
    if (hold_trig) begin
      step();
      trig = 1'b0;
      if (done) ndone++;
      check("trig_on_done_ignored", busy, 0);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) ndone++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nhs, nd;
    bit early, started, ok;

    rst_n = 1'b0; cen = 1'b1; trig = 1'b0; abort = 1'b0; out_ready = 1'b0;
    cnt = '0; mixed = 10'd100;
    cen8 = 1'b0; trig8 = 1'b0; abort8 = 1'b0; out_ready8 = 1'b0;
    cnt8 = '0; s8 = 5'd25; mixed8 = 10'd75;

    step(); step();
    check("rst_busy0", busy, 0);
    check("rst_valid0", out_valid, 0);
    check("rst_done0", done, 0);
    check("rst_err0", err, 0);
    check("rst_data0", out_data, 0);
    check("rst_slot0", out_slot, 0);
    check("rst_busy8", busy8, 0);
    rst_n = 1'b1;
    step();

    // Basic frame, trigger at cnt=5, sink always ready
    trig_at(5'd5);
    check("t1_busy", busy, 1);
    wait_valid(200, n);
    check("t1_latency", n, 57);
    drain(100, -1, 0, 1'b0, nhs, nd);
    check("t1_count", nhs, 32);
    check("t1_done", nd, 1);
    check("t1_err", err, 0);

    // STG=8, clock enable every 4th clk
    trig8 = 1'b1;
    step();
    trig8 = 1'b0;
    check("t2_busy", busy8, 1);
    started = 1'b0; n = 0; early = 1'b0; ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (cen8) begin
        if (started) n++;
        else if (s8 == 5'd0) begin
          started = 1'b1;
          n = 1;
        end
      end
      step();
      if (started && n == 32) begin
        ok = 1'b1;
        break;
      end
      if (out_valid8) early = 1'b1;
    end
    check("t2_reached", ok, 1);
    check("t2_no_early_valid", early, 0);
    check("t2_valid_at_32", out_valid8, 1);
    check("t2_err", err8, 0);
    out_ready8 = 1'b1;
    for (int k = 0; k < 32; k++) begin
      check("t2_slot", out_slot8, k);
      check("t2_data", out_data8, 3 * k);
      step();
    end
    out_ready8 = 1'b0;
    check("t2_done", done8, 1);
    check("t2_busy_end", busy8, 0);
    check("t2_valid_end", out_valid8, 0);

    // Random 30% ready with trig held high throughout drain
    trig_at(5'd20);
    wait_valid(200, n);
    drain(30, -1, 0, 1'b1, nhs, nd);
    check("t3_count", nhs, 32);
    check("t3_done", nd, 1);

    // Slot counter jumps 10 -> 12 mid-capture
    trig_at(5'd5);
    n = 0;
    while (cnt != 5'd0 && n < 64) begin
      step();
      n++;
    end
    skip_armed = 1'b1;
    n = 0;
    while (!err && n < 100) begin
      step();
      n++;
    end
    check("t4_err_latency", n, 12);
    check("t4_err", err, 1);
    check("t4_busy_after_err", busy, 1);
    check("t4_valid_after_err", out_valid, 0);
    wait_valid(200, n);
    drain(100, -1, 0, 1'b0, nhs, nd);
    check("t4_count", nhs, 32);
    check("t4_done", nd, 1);
    check("t4_err_sticky", err, 1);

    // Abort during capture, then during drain at entry 7
    trig_at(5'd5);
    for (int i = 0; i < 30; i++) step();
    check("t5_busy_capture", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t5_cap_busy", busy, 0);
    check("t5_cap_valid", out_valid, 0);
    check("t5_cap_done", done, 0);
    check("t5_err_kept", err, 1);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) nd++;
    end
    check("t5_cap_no_done", nd, 0);
    trig_at(5'd5);
    wait_valid(200, n);
    drain(100, 7, 1, 1'b0, nhs, nd);
    check("t5_abort_at", nhs, 7);
    nd = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done) nd++;
    end
    check("t5_drain_no_done", nd, 0);
    trig_at(5'd5);
    wait_valid(200, n);
    drain(100, -1, 0, 1'b0, nhs, nd);
    check("t5_count", nhs, 32);
    check("t5_done", nd, 1);

    // Asynchronous reset mid-drain with trig held high
    trig_at(5'd5);
    wait_valid(200, n);
    drain(100, 10, 2, 1'b1, nhs, nd);
    check("t6_stop", nhs, 10);
    step();
    rst_n = 1'b1;
    step();
    check("t6_err_cleared", err, 0);
    check("t6_busy", busy, 0);
    check("t6_valid", out_valid, 0);
    trig_at(5'd5);
    wait_valid(200, n);
    check("t6_latency", n, 57);
    drain(100, -1, 0, 1'b0, nhs, nd);
    check("t6_count", nhs, 32);
    check("t6_done", nd, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slot_snap_ctrl.md
Name: slot_snap_ctrl

Overview:
- Capture controller for the 32-slot time-multiplexed operator/channel pipeline signals.
- On a trigger, it aligns to slot 0 of a chosen pipeline stage and snapshots one complete 32-slot frame of a mixed signal into an internal buffer.
- It then streams the 32 entries out in slot order over a valid/ready interface.
- Used by verification benches and debug probes to read out coherent per-slot frames without a free-running per-slot register bank.

Parameters:
- W, 10, width of the multiplexed data signal.
- STG, 0, pipeline stage of the probed signal (signal xx_VIII -> STG=8); range 0..31.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; slot pipeline advances only on cycles with cen=1
- mixed  in  W  time-multiplexed data, valid on cen cycles
- cnt  in  5  global slot counter
- trig  in  1  capture request, sampled every clk
- abort  in  1  synchronous abort, returns to IDLE
- busy  out  1  high in any state other than IDLE
- out_valid  out  1  output entry valid
- out_ready  in  1  sink accepts entry
- out_data  out  W  captured slot data
- out_slot  out  5  slot index of out_data
- done  out  1  one-clk pulse after the last entry is accepted
- err  out  1  sticky: slot sequence discontinuity seen during capture

Behaviour:
- Adjusted slot: slot = (cnt + 33 - STG) mod 32, computed combinationally in 6 bits, truncated to 5.
- States: IDLE, ALIGN, CAPTURE, DRAIN. All state and outputs are registered.
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0, out_valid=0, out_data=0, out_slot=0, done=0, err=0, write/read indices=0.
  - Buffer contents are undefined after reset.
- IDLE:
  - trig=1 -> ALIGN on the next clk; busy=1 from that cycle.
- ALIGN:
  - Waits for a cen=1 cycle with slot==0.
  - On that cycle: buf[0]<=mixed, widx<=1, -> CAPTURE.
  - Cycles with cen=0 are ignored.
- CAPTURE:
  - On each cen=1 cycle: if slot==widx, then buf[widx]<=mixed and widx increments.
  - If slot!=widx: err<=1 and -> ALIGN; no write, widx reset.
  - The write with widx==31 -> DRAIN on the next clk.
  - 32 consecutive cen cycles are required; cen=0 gaps of any length are allowed.
- DRAIN:
  - First DRAIN cycle: out_valid=1, out_data=buf[0], out_slot=0.
  - Handshake = out_valid & out_ready.
  - On a handshake with ridx<31: present buf[ridx+1] on the next clk. No bubble, so back-to-back acceptance gives one entry per clk.
  - While out_ready=0: out_data, out_slot and out_valid are held stable.
  - On a handshake with ridx==31: out_valid<=0, done<=1 for one clk, -> IDLE, busy<=0.
- trig while busy: ignored (not queued).
- trig in the same cycle as done: ignored. The new capture requires trig while in IDLE.
- abort=1 in any state:
  - -> IDLE next clk; out_valid<=0; no done pulse.
  - err is retained.
  - abort has priority over trig and over the handshake in the same cycle.
- err clears only on reset.
- Total latency from trig (IDLE) to first out_valid: 1 clk + wait until slot 0 + 32 cen cycles + 1 clk.

Test Plan:
- cen=1 every clk, STG=0, mixed=cnt+100, trig at cnt=5, out_ready=1 -> 32 entries out_slot 0..31 with out_data=(slot-1 mod 32)+100; done pulses once; err=0.
- STG=8, cen every 4th clk, mixed=slot*3 -> out_data[k]=3*k for k=0..31; capture starts only on the first cen with (cnt+25) mod 32 == 0.
- out_ready random 30% during DRAIN -> out_data/out_slot never change while valid&!ready; exactly 32 handshakes; done exactly 1 clk after the 32nd handshake.
- Force cnt to skip a value mid-capture (jump 10->12) -> err=1 sticky, state returns to ALIGN, next full frame captured correctly, done still asserted.
- abort asserted during CAPTURE and again during DRAIN at entry 7 -> busy=0 and out_valid=0 the next clk; no done pulse; a subsequent trig gives a complete 32-entry frame.
- rst_n low mid-DRAIN (asynchronous, between edges) -> out_valid=0, busy=0, done=0 immediately; trig held high during DRAIN is ignored.
